// File: rtl/hd_timing_pkg.sv
// 720p50 raster constants and shared raster helpers for the HD timing path.
// Sync decode works on plain counter values so other raster users can reuse it.
package hd_timing_pkg;

  localparam int unsigned H_ACTIVE_720P  = 1280;
  localparam int unsigned H_FP_720P      = 8;
  localparam int unsigned H_SYNC_720P    = 32;
  localparam int unsigned H_BP_720P      = 40;
  localparam int unsigned V_ACTIVE_720P  = 720;
  localparam int unsigned V_FP_720P      = 3;
  localparam int unsigned V_SYNC_720P    = 5;
  localparam int unsigned V_BP_720P      = 22;
  localparam int unsigned CLK_DIV_720P   = 2;
  localparam int unsigned LOCK_LINE_720P = 725;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } region_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic in_active(input int unsigned pos, input int unsigned active);
    return pos < active;
  endfunction

  // Sync sits after active video and the front porch, for sync-width positions.
  function automatic logic in_sync(input int unsigned pos, input int unsigned active,
                                   input int unsigned fp, input int unsigned sync);
    return (pos >= active + fp) && (pos < active + fp + sync);
  endfunction

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/hd_timing_gen_pix_div.sv
// Pixel divider: a clk-domain phase counter giving the pixel strobe and a
// square pixel-phase clock, both registered one clk after the phase they describe.
module hd_pix_div
  import hd_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_720P
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick,
  output logic pix_en,
  output logic hd_clk
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  generate
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("hd_pix_div: CLK_DIV must be even and at least 2");
    end
  endgenerate

  logic [DW-1:0] div;
  logic          hd_phase;

  always_comb begin
    pix_tick = (div == DIV_LAST);
    hd_phase = (div < DIV_HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      pix_en <= 1'b0;
      hd_clk <= 1'b0;
    end else begin
      div    <= pix_tick ? '0 : div + 1'b1;
      pix_en <= pix_tick;
      hd_clk <= hd_phase;
    end
  end

endmodule

// File: rtl/hd_timing_gen.sv
// HD raster timing generator with optional genlock of the line counter to
// the PAL frame-end pulse; all outputs registered in the clk domain.
module hd_timing_gen
  import hd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_720P,
  parameter int unsigned H_FP      = H_FP_720P,
  parameter int unsigned H_SYNC    = H_SYNC_720P,
  parameter int unsigned H_BP      = H_BP_720P,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_720P,
  parameter int unsigned V_FP      = V_FP_720P,
  parameter int unsigned V_SYNC    = V_SYNC_720P,
  parameter int unsigned V_BP      = V_BP_720P,
  parameter int unsigned CLK_DIV   = CLK_DIV_720P,
  parameter logic        SYNC_POL  = 1'b1,
  parameter int unsigned LOCK_LINE = LOCK_LINE_720P
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_lock_en,
  input  logic        i_frame_sync,
  output logic        o_pix_en,
  output logic        o_hd_clk,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [10:0] o_y,
  output logic        o_frame_start,
  output logic        o_locked
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] LOCK_V = VW'(LOCK_LINE);

  generate
    if (LOCK_LINE >= V_TOTAL) begin : g_bad_lock
      $error("hd_timing_gen: LOCK_LINE must be below V_TOTAL");
    end
    if (H_TOTAL < 2 || V_TOTAL < 2 || HW > 12 || VW > 11) begin : g_bad_raster
      $error("hd_timing_gen: raster totals out of range for the counter ports");
    end
  endgenerate

  logic          pix_tick;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [VW-1:0] v_nat;
  logic          line_end;
  logic          frame_hit;
  logic          load;
  logic          pend;
  region_t       region;

  hd_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk     (clk),
    .reset   (reset),
    .pix_tick(pix_tick),
    .pix_en  (o_pix_en),
    .hd_clk  (o_hd_clk)
  );

  always_comb begin
    line_end     = pix_tick && (h == H_LAST);
    frame_hit    = i_lock_en && i_frame_sync;
    // A pulse landing on the line-end clk is honoured at that same line end.
    load         = i_lock_en && line_end && (pend || frame_hit);
    v_nat        = (v == V_LAST) ? '0 : v + 1'b1;
    region.de    = in_active(32'(h), H_ACTIVE) && in_active(32'(v), V_ACTIVE);
    region.hsync = in_sync(32'(h), H_ACTIVE, H_FP, H_SYNC);
    region.vsync = in_sync(32'(v), V_ACTIVE, V_FP, V_SYNC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        h <= '0;
        v <= load ? LOCK_V : v_nat;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !i_lock_en) begin
      pend     <= 1'b0;
      o_locked <= 1'b0;
    end else if (load) begin
      pend     <= 1'b0;
      o_locked <= (v_nat == LOCK_V);
    end else if (frame_hit) begin
      pend     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= sync_level(region.hsync, SYNC_POL);
      o_vsync       <= sync_level(region.vsync, SYNC_POL);
      o_de          <= region.de;
      o_x           <= 12'(h);
      o_y           <= 11'(v);
      o_frame_start <= pix_tick && (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_hd_timing_gen.sv
// Scoreboard bench: three raster configurations, a pixel-level reference model
// feeding per-instance queues, and a negedge monitor popping on each pixel strobe.
`timescale 1ns/1ps
module tb_hd_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic        hd_clk;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic        fs;
    logic        locked;
  } obs_t;

  typedef struct packed {
    logic [11:0] x;
    logic [10:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        locked;
  } exp_t;

  // Instance 0: 720p50 defaults; 1: medium raster for genlock; 2: tiny raster.
  localparam int HA [3] = '{1280, 8, 4};
  localparam int HF [3] = '{8, 2, 1};
  localparam int HS [3] = '{32, 3, 2};
  localparam int HB [3] = '{40, 3, 1};
  localparam int VA [3] = '{720, 10, 3};
  localparam int VF [3] = '{3, 2, 1};
  localparam int VS [3] = '{5, 2, 1};
  localparam int VB [3] = '{22, 4, 1};
  localparam int DV [3] = '{2, 2, 4};
  localparam int LK [3] = '{725, 14, 4};
  localparam bit POL[3] = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock_b = 1'b0;
  logic fs_b = 1'b0;

  logic        pe[3], hd[3], hsy[3], vsy[3], de[3], fst[3], lk[3];
  logic [11:0] ox[3];
  logic [10:0] oy[3];
  obs_t        obs[3];

  int checks = 0;
  int errors = 0;

  int          mx[3], my[3];
  int unsigned mc[3];
  bit          mpend[3], mlock[3], exp_hd[3], exp_pe[3], rst_seen[3];
  bit          live = 1'b0;
  exp_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  hd_timing_gen u_dut0 (
    .clk(clk), .reset(rst), .i_lock_en(1'b0), .i_frame_sync(1'b0),
    .o_pix_en(pe[0]), .o_hd_clk(hd[0]), .o_hsync(hsy[0]), .o_vsync(vsy[0]), .o_de(de[0]),
    .o_x(ox[0]), .o_y(oy[0]), .o_frame_start(fst[0]), .o_locked(lk[0])
  );

  hd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CLK_DIV(2), .SYNC_POL(1'b1), .LOCK_LINE(14)
  ) u_dut1 (
    .clk(clk), .reset(rst), .i_lock_en(lock_b), .i_frame_sync(fs_b),
    .o_pix_en(pe[1]), .o_hd_clk(hd[1]), .o_hsync(hsy[1]), .o_vsync(vsy[1]), .o_de(de[1]),
    .o_x(ox[1]), .o_y(oy[1]), .o_frame_start(fst[1]), .o_locked(lk[1])
  );

  hd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .SYNC_POL(1'b0), .LOCK_LINE(4)
  ) u_dut2 (
    .clk(clk), .reset(rst), .i_lock_en(1'b0), .i_frame_sync(1'b0),
    .o_pix_en(pe[2]), .o_hd_clk(hd[2]), .o_hsync(hsy[2]), .o_vsync(vsy[2]), .o_de(de[2]),
    .o_x(ox[2]), .o_y(oy[2]), .o_frame_start(fst[2]), .o_locked(lk[2])
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      obs[k] = {pe[k], hd[k], hsy[k], vsy[k], de[k], ox[k], oy[k], fst[k], lk[k]};
    end
  end

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event within bound, expected one (t=%0t)", name, $time);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Pixel-level reference: one pixel every DV clks, raster position by arithmetic.
  task automatic model_step(input int k, input bit le, input bit fsync);
    int   ht, vt, ph, nat;
    bit   fsh, lend;
    exp_t e;
    if (rst) begin
      mc[k] = 0; mx[k] = 0; my[k] = 0; mpend[k] = 0; mlock[k] = 0;
      exp_hd[k] = 0; exp_pe[k] = 0; rst_seen[k] = 1;
      return;
    end
    rst_seen[k] = 0;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    ph = int'(mc[k] % DV[k]);
    exp_hd[k] = (ph < DV[k] / 2);
    exp_pe[k] = (ph == DV[k] - 1);
    fsh  = le && fsync;
    lend = exp_pe[k] && (mx[k] == ht - 1);
    if (!le) begin
      mpend[k] = 0;
      mlock[k] = 0;
    end
    if (exp_pe[k]) begin
      e.x  = 12'(mx[k]);
      e.y  = 11'(my[k]);
      e.de = (mx[k] < HA[k]) && (my[k] < VA[k]);
      e.hs = (mx[k] >= HA[k] + HF[k] && mx[k] < HA[k] + HF[k] + HS[k]) ? POL[k] : !POL[k];
      e.vs = (my[k] >= VA[k] + VF[k] && my[k] < VA[k] + VF[k] + VS[k]) ? POL[k] : !POL[k];
      e.fs = (mx[k] == 0) && (my[k] == 0);
      if (lend) begin
        mx[k] = 0;
        nat = (my[k] + 1) % vt;
        if (le && (mpend[k] || fsh)) begin
          mlock[k] = (nat == LK[k]);
          my[k] = LK[k];
          mpend[k] = 0;
        end else begin
          my[k] = nat;
        end
      end else begin
        mx[k]++;
      end
      e.locked = mlock[k];
      qpush(k, e);
    end
    if (fsh && !lend) mpend[k] = 1;
    mc[k]++;
  endtask

  task automatic mon_step(input int k);
    obs_t o, r;
    exp_t e;
    o = obs[k];
    if (rst_seen[k]) begin
      r = '0;
      r.hs = !POL[k];
      r.vs = !POL[k];
      chk("reset_state", k, o, r);
      return;
    end
    chk("hd_clk", k, o.hd_clk, exp_hd[k]);
    chk("pix_en", k, o.pix_en, exp_pe[k]);
    if (o.pix_en) begin
      chk("sb_pending", k, qsize(k) > 0, 1);
      if (qsize(k) > 0) begin
        qpop(k, e);
        chk("x", k, o.x, e.x);
        chk("y", k, o.y, e.y);
        chk("de", k, o.de, e.de);
        chk("hsync", k, o.hs, e.hs);
        chk("vsync", k, o.vs, e.vs);
        chk("frame_start", k, o.fs, e.fs);
        chk("locked", k, o.locked, e.locked);
      end
    end else begin
      chk("frame_start_idle", k, o.fs, 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k, (k == 1) ? lock_b : 1'b0, (k == 1) ? fs_b : 1'b0);
      live = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) for (int k = 0; k < 3; k++) mon_step(k);
    end
  end

  task automatic wait_model(input int k, input int ty, input int tx, input bit at_tick,
                            input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((ty < 0 || my[k] == ty) && mx[k] == tx &&
          (!at_tick || int'(mc[k] % DV[k]) == DV[k] - 1)) return;
    end
    timeout(name);
  endtask

  task automatic pulse_b();
    fs_b = 1'b1;
    @(negedge clk);
    fs_b = 1'b0;
  endtask

  task automatic check_next_line(input string name, input int exp_y, input bit exp_lock);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obs[1].pix_en && obs[1].x == 12'd0) begin
        chk({name, "_y"}, 1, obs[1].y, exp_y);
        chk({name, "_locked"}, 1, obs[1].locked, exp_lock);
        return;
      end
    end
    timeout(name);
  endtask

  initial begin
    int  n_hs0, n_de0, n_hs1, n_hsl2, n_hd2;
    bit  found;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Window of exactly one default line (2720 clk), a whole number of lines for all.
    n_hs0 = 0; n_de0 = 0; n_hs1 = 0; n_hsl2 = 0; n_hd2 = 0;
    for (int i = 0; i < 2720; i++) begin
      @(negedge clk);
      if (obs[0].hs) n_hs0++;
      if (obs[0].de) n_de0++;
      if (obs[1].hs) n_hs1++;
      if (!obs[2].hs) n_hsl2++;
      if (obs[2].hd_clk) n_hd2++;
    end
    chk("hsync_clks_per_line", 0, n_hs0, 64);
    chk("de_clks_per_line", 0, n_de0, 2560);
    chk("hsync_clks_85_lines", 1, n_hs1, 510);
    chk("hsync_low_clks_85_lines", 2, n_hsl2, 680);
    chk("hd_clk_high_clks", 2, n_hd2, 1360);

    lock_b = 1'b1;
    wait_model(1, 3, 5, 1'b0, 2000, "wait_y3");
    pulse_b();
    check_next_line("lock_far", 14, 1'b0);

    wait_model(1, 13, 5, 1'b0, 2000, "wait_y13");
    pulse_b();
    check_next_line("lock_natural", 14, 1'b1);

    wait_model(1, 9, 3, 1'b0, 2000, "wait_y9");
    pulse_b();
    wait_model(1, 9, 8, 1'b0, 100, "wait_y9_x8");
    lock_b = 1'b0;
    check_next_line("lock_drop", 10, 1'b0);
    check_next_line("lock_drop_run", 11, 1'b0);
    lock_b = 1'b1;
    check_next_line("lock_reenable", 12, 1'b0);

    wait_model(1, 5, 15, 1'b1, 2000, "wait_y5_end");
    pulse_b();
    check_next_line("lock_coincident", 14, 1'b0);

    wait_model(1, 13, 15, 1'b1, 2000, "wait_y13_end");
    pulse_b();
    check_next_line("coincident_natural", 14, 1'b1);

    wait_model(1, 7, 2, 1'b0, 2000, "wait_y7");
    pulse_b();
    wait_model(1, 7, 9, 1'b0, 100, "wait_y7_x9");
    pulse_b();
    check_next_line("double_pulse", 14, 1'b0);
    check_next_line("double_pulse_once", 15, 1'b0);

    // Abort mid-line on the default raster and expect a clean restart.
    wait_model(0, -1, 600, 1'b0, 3000, "wait_x600");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (obs[0].pix_en) begin
        found = 1'b1;
        chk("restart_x", 0, obs[0].x, 0);
        chk("restart_y", 0, obs[0].y, 0);
        chk("restart_frame_start", 0, obs[0].fs, 1);
      end
    end
    if (!found) timeout("restart_pix_en");

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) lock_b = !lock_b;
      fs_b = ($urandom_range(0, 39) == 0);
    end
    fs_b = 1'b0;
    lock_b = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("sb_drain", k, qsize(k), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
